// File: rtl/operand_fetch.sv
// Decode-to-execute stage: architectural register file, two-operand read with
// same-cycle writeback bypass, one-bubble RAW interlock, and registered operand bundle.
module operand_fetch #(
  parameter int unsigned ADDR   = 16,
  parameter int unsigned W_OPR  = 32,
  parameter int unsigned W_RD   = 5,
  parameter int unsigned W_IMM  = 16,
  parameter int unsigned D_INFO = 16,
  parameter int unsigned WRSV   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              v_i,
  input  logic [ADDR-1:0]   pc_i,
  input  logic [W_IMM-1:0]  imm_i,
  input  logic [D_INFO-1:0] d_info_i,
  input  logic [W_RD-1:0]   rs0_i,
  input  logic [W_RD-1:0]   rs1_i,
  input  logic              use0_i,
  input  logic              use1_i,
  input  logic [W_RD-1:0]   wb_r_i,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   wb_addr_i,
  input  logic [W_OPR-1:0]  wb_data_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              stall_o,
  output logic              v_o,
  output logic [ADDR-1:0]   pc_o,
  output logic [W_IMM-1:0]  imm_o,
  output logic [D_INFO-1:0] d_info_o,
  output logic [W_RD-1:0]   wb_r_o,
  output logic [W_OPR-1:0]  opr0_o,
  output logic [W_OPR-1:0]  opr1_o
);

  localparam int unsigned NumRegs = 1 << W_RD;

  logic [W_OPR-1:0]  rf_q [NumRegs];
  logic [W_OPR-1:0]  rd0, rd1;
  logic              pend, hazard;

  logic              v_d, v_q;
  logic [ADDR-1:0]   pc_d, pc_q;
  logic [W_IMM-1:0]  imm_d, imm_q;
  logic [D_INFO-1:0] d_info_d, d_info_q;
  logic [W_RD-1:0]   wb_r_d, wb_r_q;
  logic [W_OPR-1:0]  opr0_d, opr0_q;
  logic [W_OPR-1:0]  opr1_d, opr1_q;

  // Writeback lands even while the stage is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
    end else if (wb_i) begin
      rf_q[wb_addr_i] <= wb_data_i;
    end
  end

  always_comb begin
    rd0 = (wb_i && (wb_addr_i == rs0_i)) ? wb_data_i : rf_q[rs0_i];
    rd1 = (wb_i && (wb_addr_i == rs1_i)) ? wb_data_i : rf_q[rs1_i];
  end

  // The instruction in execute produces its result next cycle, so one bubble suffices.
  always_comb begin
    pend    = v_q & d_info_q[WRSV];
    hazard  = v_i & ~flush_i & pend &
              ((use0_i & (rs0_i == wb_r_q)) | (use1_i & (rs1_i == wb_r_q)));
    stall_o = stall_i | hazard;
  end

  always_comb begin
    v_d      = v_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    d_info_d = d_info_q;
    wb_r_d   = wb_r_q;
    opr0_d   = opr0_q;
    opr1_d   = opr1_q;
    if (!stall_i) begin
      if (flush_i || hazard) begin
        v_d = 1'b0;
      end else begin
        v_d      = v_i;
        pc_d     = pc_i;
        imm_d    = imm_i;
        d_info_d = d_info_i;
        wb_r_d   = wb_r_i;
        opr0_d   = rd0;
        opr1_d   = rd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q      <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      d_info_q <= '0;
      wb_r_q   <= '0;
      opr0_q   <= '0;
      opr1_q   <= '0;
    end else begin
      v_q      <= v_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      d_info_q <= d_info_d;
      wb_r_q   <= wb_r_d;
      opr0_q   <= opr0_d;
      opr1_q   <= opr1_d;
    end
  end

  assign v_o      = v_q;
  assign pc_o     = pc_q;
  assign imm_o    = imm_q;
  assign d_info_o = d_info_q;
  assign wb_r_o   = wb_r_q;
  assign opr0_o   = opr0_q;
  assign opr1_o   = opr1_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized and directed bench for operand_fetch against a cycle-level reference model
// built from the stage's read, bypass, interlock and update rules.
module tb_operand_fetch;

  localparam int unsigned ADDR   = 16;
  localparam int unsigned W_OPR  = 32;
  localparam int unsigned W_RD   = 5;
  localparam int unsigned W_IMM  = 16;
  localparam int unsigned D_INFO = 16;
  localparam int unsigned WRSV   = 0;
  localparam int unsigned NREG   = 1 << W_RD;

  logic              clk = 1'b0;
  logic              reset;
  logic              v_i, use0_i, use1_i, wb_i, flush_i, stall_i;
  logic [ADDR-1:0]   pc_i;
  logic [W_IMM-1:0]  imm_i;
  logic [D_INFO-1:0] d_info_i;
  logic [W_RD-1:0]   rs0_i, rs1_i, wb_r_i, wb_addr_i;
  logic [W_OPR-1:0]  wb_data_i;
  logic              stall_o, v_o;
  logic [ADDR-1:0]   pc_o;
  logic [W_IMM-1:0]  imm_o;
  logic [D_INFO-1:0] d_info_o;
  logic [W_RD-1:0]   wb_r_o;
  logic [W_OPR-1:0]  opr0_o, opr1_o;

  always #5 clk = ~clk;

  operand_fetch #(
    .ADDR(ADDR), .W_OPR(W_OPR), .W_RD(W_RD), .W_IMM(W_IMM), .D_INFO(D_INFO), .WRSV(WRSV)
  ) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .pc_i(pc_i), .imm_i(imm_i), .d_info_i(d_info_i),
    .rs0_i(rs0_i), .rs1_i(rs1_i), .use0_i(use0_i), .use1_i(use1_i), .wb_r_i(wb_r_i),
    .wb_i(wb_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .flush_i(flush_i),
    .stall_i(stall_i), .stall_o(stall_o), .v_o(v_o), .pc_o(pc_o), .imm_o(imm_o),
    .d_info_o(d_info_o), .wb_r_o(wb_r_o), .opr0_o(opr0_o), .opr1_o(opr1_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: register contents and the bundle held for execute.
  logic [W_OPR-1:0]  m_rf [NREG];
  logic              m_v;
  logic [ADDR-1:0]   m_pc;
  logic [W_IMM-1:0]  m_imm;
  logic [D_INFO-1:0] m_d;
  logic [W_RD-1:0]   m_wbr;
  logic [W_OPR-1:0]  m_o0, m_o1;
  logic              m_stall;
  logic              last_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    m_v = 1'b0; m_pc = '0; m_imm = '0; m_d = '0; m_wbr = '0; m_o0 = '0; m_o1 = '0;
    m_stall = 1'b0;
  endtask

  // One clock: check stall_o before the edge, advance the model, check the bundle after.
  task automatic tick();
    logic hz, st, fl, vi, wb;
    logic [W_OPR-1:0] r0, r1, wd;
    logic [W_RD-1:0] wa;
    @(negedge clk);
    hz = v_i & ~flush_i & m_v & m_d[WRSV] &
         ((use0_i & (rs0_i == m_wbr)) | (use1_i & (rs1_i == m_wbr)));
    check("stall_o", stall_o, stall_i | hz);
    last_stall = stall_o;
    m_stall = stall_i | hz;
    r0 = (wb_i && wb_addr_i == rs0_i) ? wb_data_i : m_rf[rs0_i];
    r1 = (wb_i && wb_addr_i == rs1_i) ? wb_data_i : m_rf[rs1_i];
    st = stall_i; fl = flush_i; vi = v_i; wb = wb_i; wa = wb_addr_i; wd = wb_data_i;
    @(posedge clk);
    #1;
    if (wb) m_rf[wa] = wd;
    if (!st) begin
      if (fl || hz) m_v = 1'b0;
      else begin
        m_v = vi; m_pc = pc_i; m_imm = imm_i; m_d = d_info_i; m_wbr = wb_r_i;
        m_o0 = r0; m_o1 = r1;
      end
    end
    check("v_o", v_o, m_v);
    if (m_v) begin
      check("pc_o", pc_o, m_pc);
      check("imm_o", imm_o, m_imm);
      check("d_info_o", d_info_o, m_d);
      check("wb_r_o", wb_r_o, m_wbr);
      check("opr0_o", opr0_o, m_o0);
      check("opr1_o", opr1_o, m_o1);
    end
  endtask

  task automatic drive(input logic v, input logic [W_RD-1:0] rs0, input logic [W_RD-1:0] rs1,
                       input logic u0, input logic u1, input logic [D_INFO-1:0] d,
                       input logic [W_RD-1:0] wbr, input logic wb, input logic [W_RD-1:0] wa,
                       input logic [W_OPR-1:0] wd, input logic fl, input logic st);
    v_i = v; rs0_i = rs0; rs1_i = rs1; use0_i = u0; use1_i = u1; d_info_i = d;
    wb_r_i = wbr; wb_i = wb; wb_addr_i = wa; wb_data_i = wd; flush_i = fl; stall_i = st;
    pc_i = ADDR'($urandom); imm_i = W_IMM'($urandom);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #22 reset = 1'b1;

    // Reset mid-stream
    drive(1, 1, 2, 1, 1, 16'h0001, 3, 1, 3, 32'h55, 0, 0);
    tick();
    check("pre_reset_v", v_o, 1'b1);
    stall_i = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_v", v_o, 1'b0);
    check("rst_pc", pc_o, '0);
    check("rst_opr0", opr0_o, '0);
    check("rst_d_info", d_info_o, '0);
    check("rst_stall_passthru", stall_o, 1'b1);
    model_reset();
    stall_i = 1'b0;
    #1 reset = 1'b1;
    drive(1, 3, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    tick();
    check("post_rst_r3", opr0_o, 32'h0);

    // Independent ops with preloaded r2/r3
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 32'd5, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'd7, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 16'h0001, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 3, 1, 1, 16'h0000, 8, 0, 0, 0, 0, 0); tick();
    check("indep_no_stall", last_stall, 1'b0);
    check("indep_opr0", opr0_o, 32'd5);
    check("indep_opr1", opr1_o, 32'd7);

    // Back-to-back RAW: one bubble, then bypassed result
    drive(1, 0, 0, 0, 0, 16'h0001, 4, 0, 0, 0, 0, 0); tick();
    drive(1, 4, 0, 1, 0, 16'h0000, 5, 0, 0, 0, 0, 0); tick();
    check("raw_stall", last_stall, 1'b1);
    check("raw_bubble", v_o, 1'b0);
    wb_i = 1'b1; wb_addr_i = 4; wb_data_i = 32'h1234;
    tick();
    check("raw_released", last_stall, 1'b0);
    check("raw_opr0", opr0_o, 32'h1234);

    // Same-cycle bypass, then register file holds the value
    drive(1, 0, 9, 0, 1, 16'h0000, 0, 1, 9, 32'hDEAD, 0, 0); tick();
    check("byp_opr1", opr1_o, 32'hDEAD);
    drive(1, 9, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0); tick();
    check("byp_rf", opr0_o, 32'hDEAD);

    // Downstream stall with concurrent writeback
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 1, 1, 16'h0001, 7, 1, 10, 32'hBEEF + i, 0, 1); tick();
      check("dstall_stall_o", last_stall, 1'b1);
      check("dstall_hold", opr0_o, 32'hDEAD);
    end
    drive(1, 10, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0); tick();
    check("dstall_wb_landed", opr0_o, 32'hBEEF + 2);

    // Flush kills a would-be hazard; flush under stall holds outputs
    drive(1, 0, 0, 0, 0, 16'h0001, 6, 0, 0, 0, 0, 0); tick();
    drive(1, 6, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 1, 0); tick();
    check("flush_no_stall", last_stall, 1'b0);
    check("flush_v", v_o, 1'b0);
    drive(1, 2, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 3, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 1, 1); tick();
    check("flush_stall_hold_v", v_o, 1'b1);
    check("flush_stall_hold_opr", opr0_o, 32'd5);

    // Randomized stream; upstream re-presents while stalled
    for (int n = 0; n < 3000; n++) begin
      if (!m_stall) begin
        v_i = ($urandom_range(0, 3) != 0);
        pc_i = ADDR'($urandom); imm_i = W_IMM'($urandom); d_info_i = D_INFO'($urandom);
        rs0_i = W_RD'($urandom_range(0, 7)); rs1_i = W_RD'($urandom_range(0, 7));
        use0_i = 1'($urandom); use1_i = 1'($urandom);
        wb_r_i = W_RD'($urandom_range(0, 7));
      end
      wb_i = 1'($urandom); wb_addr_i = W_RD'($urandom_range(0, 7)); wb_data_i = $urandom;
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      tick();
    end

    // Sweep the whole register file
    for (int r = 0; r < NREG; r++) begin
      drive(1, W_RD'(r), W_RD'(NREG - 1 - r), 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-to-execute pipeline stage. Holds the architectural register file and reads up to two source operands per instruction. Bypasses the same-cycle writeback from the execute stage and interlocks on read-after-write against the instruction currently in execute. Registers a complete operand bundle (pc, imm, opr0, opr1, d_info, wb_r, valid) for the execute stage.

## Interface
- ADDR, 16, pc width
- W_OPR, 32, operand/register width
- W_RD, 5, register index width; register file has 2^W_RD entries
- W_IMM, 16, immediate width
- D_INFO, 16, decoded-info bundle width, passed through unmodified
- WRSV, 0, bit index in d_info meaning "instruction writes wb_r"
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- v_i  in  1  incoming instruction valid
- pc_i  in  ADDR  instruction pc
- imm_i  in  W_IMM  immediate
- d_info_i  in  D_INFO  decoded info
- rs0_i, rs1_i  in  W_RD  source register indices
- use0_i, use1_i  in  1  source actually read; gates hazard check
- wb_r_i  in  W_RD  destination index
- wb_i  in  1  writeback enable from execute (execute's wb_o)
- wb_addr_i  in  W_RD  writeback index (execute's wb_r_o)
- wb_data_i  in  W_OPR  writeback data (execute's result_o)
- flush_i  in  1  kill incoming instruction (taken branch in execute)
- stall_i  in  1  downstream stall
- stall_o  out  1  upstream stall
- v_o  out  1  bundle valid
- pc_o, imm_o, d_info_o, wb_r_o  out  ADDR/W_IMM/D_INFO/W_RD  registered pass-through
- opr0_o, opr1_o  out  W_OPR  registered operands

## Operation
- Register file: 2^W_RD x W_OPR flops, all reset to 0; no hardwired-zero register. Written at posedge when wb_i=1, regardless of stall_i.
- Operand read, per source: wb_i & wb_addr_i==rsN_i -> wb_data_i (bypass); else regfile[rsN_i]. Unused sources still read; value is don't-care but must be deterministic.
- Pending writer: pend = v_o & d_info_o[WRSV].
- hazard = v_i & ~flush_i & pend & ((use0_i & rs0_i==wb_r_o) | (use1_i & rs1_i==wb_r_o)).
- stall_o = stall_i | hazard (combinational).
- Output register update at posedge, priority order:
  1. stall_i=1: all outputs hold.
  2. flush_i=1: v_o<=0, other fields don't-care.
  3. hazard=1: v_o<=0 (one bubble), other fields don't-care.
  4. else: latch v_i and all fields; opr0_o/opr1_o get the read values above.
- Hazard resolves in exactly one bubble. Next cycle the producer sits in execute's output register, wb_i presents its result (ALU or load data), and the bypass supplies it.
- flush_i while stall_i=1 has no effect on the output register. Upstream is stalled and re-presents; the fetch stage must hold flush until the stall clears.

## Timing
- Reset (async, reset=0): v_o, pc_o, imm_o, opr0_o, opr1_o, d_info_o, wb_r_o = 0. Register file = 0. stall_o = stall_i.
- Reset mid-operation clears all state immediately; the first instruction after reset release sees pend=0.
- Latency: 1 cycle from v_i accepted to v_o.
- Throughput: 1 per cycle absent hazards and stalls.
- RAW distance 1: +1 bubble.
- RAW distance >=2: no bubble. The value comes from the bypass or the register file.
- Write and read of the same register in the same cycle: the new value is read via bypass.
- Two back-to-back writes to the same register: the last write wins in the register file.
- Upstream holds its instruction while stall_o=1. Accepted iff ~stall_o at posedge.

## Test plan
- Reset: drive reset=0 mid-stream with v_o=1 -> all outputs 0 immediately; after release, read of r3 with no writes gives opr0_o=0.
- Independent ops: I0 writes r1; I1 reads r2,r3, with r2=5 and r3=7 preloaded via wb -> no stall_o; opr0_o=5, opr1_o=7 one cycle after accept.
- Back-to-back RAW: I0 (WRSV=1, wb_r=4), then I1 use0 rs0=4. Execute returns wb_data 0x1234 the following cycle -> stall_o=1 for one cycle; one v_o=0 bubble; I1 emerges with opr0_o=0x1234.
- Bypass: wb_i=1, wb_addr=9, data=0xDEAD in the same cycle as a read of r9 -> opr1_o=0xDEAD. The register file holds 0xDEAD afterwards.
- Downstream stall: stall_i=1 for 3 cycles with v_o=1, plus a concurrent wb_i -> outputs frozen, stall_o=1, and the register write still lands.
- Flush: flush_i=1 with v_i=1 and a would-be hazard -> stall_o=stall_i=0 and v_o=0 next cycle. With stall_i=1 and flush_i=1 -> outputs hold.
